// File: rtl/regfile_2r1w_sb.sv
// 2-read/1-write register file with write-to-read bypass, pending-write scoreboard and a hardware clear sequencer.
// Optional build macro REGFILE_PRELOAD_EN: the clear sequence loads fixed preload values instead of zeros.
module regfile_2r1w_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req,
    output logic              ready,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rd1_busy,
    output logic              rd2_busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   cnt_r;
    logic [DATA_W-1:0]   mem_r [NUM_REGS];
    logic [NUM_REGS-1:0] pend_r;
    logic [NUM_REGS-1:0] pend_next_s;
    logic                run_s;
    logic                wr_ok_s;
    logic                mark_ok_s;
    logic [DATA_W-1:0]   rd1_next_s;
    logic [DATA_W-1:0]   rd2_next_s;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_wa_s;
    logic [DATA_W-1:0]   mem_wd_s;

`ifdef REGFILE_PRELOAD_EN
    function automatic logic [DATA_W-1:0] init_value(input logic [ADDR_W-1:0] idx);
        logic [4:0] low5;
        low5 = 5'(idx);
        case (low5)
            5'd9:    init_value = DATA_W'(15);
            5'd10:   init_value = DATA_W'(20);
            5'd11:   init_value = DATA_W'(25);
            5'd14:   init_value = DATA_W'(40);
            default: init_value = {DATA_W{1'b0}};
        endcase
    endfunction
`endif

    // Qualify writes and marks: only in RUN, never alongside a re-init request, never to a hardwired zero register
    always_comb begin
        run_s     = (state_r == ST_RUN);
        wr_ok_s   = run_s && we && !init_req && !(ZERO_REG && (wa == ZERO_IDX));
        mark_ok_s = run_s && mark_en && !init_req && !(ZERO_REG && (mark_addr == ZERO_IDX));
    end

    // Scoreboard next state: write clears, mark sets afterwards so a same-address mark wins
    always_comb begin
        pend_next_s = {NUM_REGS{1'b0}};
        if (run_s && !init_req) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_next_s[i] = (pend_r[i] && !(wr_ok_s && (wa == ADDR_W'(i))))
                               || (mark_ok_s && (mark_addr == ADDR_W'(i)));
            end
        end else begin
            pend_next_s = {NUM_REGS{1'b0}};
        end
    end

    // Read data selection with bypass of the write landing this cycle
    always_comb begin
        rd1_next_s = {DATA_W{1'b0}};
        rd2_next_s = {DATA_W{1'b0}};
        if (ZERO_REG && (ra1 == ZERO_IDX)) begin
            rd1_next_s = {DATA_W{1'b0}};
        end else if (wr_ok_s && (wa == ra1)) begin
            rd1_next_s = wd;
        end else begin
            rd1_next_s = mem_r[ra1];
        end
        if (ZERO_REG && (ra2 == ZERO_IDX)) begin
            rd2_next_s = {DATA_W{1'b0}};
        end else if (wr_ok_s && (wa == ra2)) begin
            rd2_next_s = wd;
        end else begin
            rd2_next_s = mem_r[ra2];
        end
    end

    // Storage write port is shared between the clear sequencer and the architectural write
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = ZERO_IDX;
        mem_wd_s = {DATA_W{1'b0}};
        if (!run_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = cnt_r;
`ifdef REGFILE_PRELOAD_EN
            mem_wd_s = init_value(cnt_r);
`else
            mem_wd_s = {DATA_W{1'b0}};
`endif
        end else begin
            mem_we_s = wr_ok_s;
            mem_wa_s = wa;
            mem_wd_s = wd;
        end
    end

    // Register array; contents are defined by the clear sequence, so no reset is needed here
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end

    // Sequencer FSM, scoreboard and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_INIT;
            cnt_r    <= ZERO_IDX;
            pend_r   <= {NUM_REGS{1'b0}};
            ready    <= 1'b0;
            rd1      <= {DATA_W{1'b0}};
            rd2      <= {DATA_W{1'b0}};
            rd1_busy <= 1'b0;
            rd2_busy <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    pend_r   <= {NUM_REGS{1'b0}};
                    rd1      <= {DATA_W{1'b0}};
                    rd2      <= {DATA_W{1'b0}};
                    rd1_busy <= 1'b0;
                    rd2_busy <= 1'b0;
                    if (cnt_r == LAST_IDX) begin
                        state_r <= ST_RUN;
                        cnt_r   <= ZERO_IDX;
                        ready   <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + ADDR_W'(1);
                        ready   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    pend_r   <= pend_next_s;
                    rd1      <= rd1_next_s;
                    rd2      <= rd2_next_s;
                    rd1_busy <= pend_next_s[ra1];
                    rd2_busy <= pend_next_s[ra2];
                    if (init_req) begin
                        state_r <= ST_INIT;
                        cnt_r   <= ZERO_IDX;
                        ready   <= 1'b0;
                    end else begin
                        ready   <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_INIT;
                    cnt_r    <= ZERO_IDX;
                    pend_r   <= {NUM_REGS{1'b0}};
                    ready    <= 1'b0;
                    rd1      <= {DATA_W{1'b0}};
                    rd2      <= {DATA_W{1'b0}};
                    rd1_busy <= 1'b0;
                    rd2_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed bench for regfile_2r1w_sb (default parameters); preload checks follow REGFILE_PRELOAD_EN.
module tb_regfile_2r1w_sb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_req;
    logic        ready;
    logic [4:0]  ra1, ra2, wa, mark_addr;
    logic [31:0] rd1, rd2, wd;
    logic        rd1_busy, rd2_busy, we, mark_en;
    int          checks = 0;
    int          errors = 0;

    regfile_2r1w_sb dut (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .ready(ready),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
        .we(we), .wa(wa), .wd(wd), .mark_en(mark_en), .mark_addr(mark_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        init_req = 1'b0; we = 1'b0; mark_en = 1'b0;
        wa = 5'd0; wd = 32'd0; mark_addr = 5'd0;
    endtask

    // Ready must stay low for 31 samples after the start edge and rise on the 32nd
    task automatic init_window(input string tag);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            chk(tag, {31'd0, ready}, (k == 32) ? 32'd1 : 32'd0);
            chk({tag, "_rd1"}, rd1, 32'd0);
            chk({tag, "_busy1"}, {31'd0, rd1_busy}, 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; idle(); ra1 = 5'd3; ra2 = 5'd0;
        @(negedge clk); @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rd1", rd1, 32'd0);
        chk("rst_rd2", rd2, 32'd0);
        rst_n = 1'b1;
        init_window("init_after_reset");

        // bypass on port 1, then normal read on port 2
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra1 = 5'd5;
        @(negedge clk); chk("bypass_rd1", rd1, 32'hDEADBEEF);
        idle(); ra2 = 5'd5;
        @(negedge clk); chk("read_rd2", rd2, 32'hDEADBEEF);

        // hardwired zero register ignores write and mark
        we = 1'b1; wa = 5'd0; wd = 32'h1234; ra1 = 5'd0; mark_en = 1'b1; mark_addr = 5'd0;
        @(negedge clk); chk("zero_bypass", rd1, 32'd0); chk("zero_busy", {31'd0, rd1_busy}, 32'd0);
        idle();
        @(negedge clk); chk("zero_read", rd1, 32'd0); chk("zero_busy2", {31'd0, rd1_busy}, 32'd0);

        // scoreboard
        mark_en = 1'b1; mark_addr = 5'd8; ra1 = 5'd8;
        @(negedge clk); chk("mark_busy", {31'd0, rd1_busy}, 32'd1);
        idle();
        @(negedge clk); chk("mark_hold", {31'd0, rd1_busy}, 32'd1);
        we = 1'b1; wa = 5'd8; wd = 32'd77;
        @(negedge clk); chk("wr_clear_data", rd1, 32'd77); chk("wr_clear_busy", {31'd0, rd1_busy}, 32'd0);
        wd = 32'd99; mark_en = 1'b1; mark_addr = 5'd8;
        @(negedge clk); chk("mark_wins_data", rd1, 32'd99); chk("mark_wins_busy", {31'd0, rd1_busy}, 32'd1);
        wa = 5'd8; wd = 32'd5; mark_addr = 5'd12; ra2 = 5'd12;
        @(negedge clk);
        chk("diff_wr_data", rd1, 32'd5); chk("diff_wr_busy", {31'd0, rd1_busy}, 32'd0);
        chk("diff_mark_busy", {31'd0, rd2_busy}, 32'd1);
        idle(); we = 1'b1; wa = 5'd20; wd = 32'h55; ra1 = 5'd20; ra2 = 5'd20;
        @(negedge clk); chk("dual_bypass1", rd1, 32'h55); chk("dual_bypass2", rd2, 32'h55);

        // re-init clears contents and flags; the concurrent write is dropped
        wa = 5'd7; wd = 32'hAA; ra1 = 5'd3;
        @(negedge clk); idle(); ra1 = 5'd7;
        @(negedge clk); chk("reg7_before", rd1, 32'hAA);
        init_req = 1'b1; we = 1'b1; wa = 5'd6; wd = 32'h66;
        @(negedge clk); idle();
        chk("init_req_ready", {31'd0, ready}, 32'd0);
        ra1 = 5'd3;
        init_window("init_after_req");
        ra1 = 5'd7; ra2 = 5'd8;
        @(negedge clk);
        chk("reg7_cleared", rd1, 32'd0); chk("reg8_cleared", rd2, 32'd0);
        chk("busy8_cleared", {31'd0, rd2_busy}, 32'd0);
        ra1 = 5'd6; ra2 = 5'd12;
        @(negedge clk);
        chk("dropped_write", rd1, 32'd0); chk("busy12_cleared", {31'd0, rd2_busy}, 32'd0);

        // preload values (or zeros)
        ra1 = 5'd9; ra2 = 5'd14;
        @(negedge clk);
`ifdef REGFILE_PRELOAD_EN
        chk("pre9", rd1, 32'd15); chk("pre14", rd2, 32'd40);
        ra1 = 5'd11; ra2 = 5'd10;
        @(negedge clk); chk("pre11", rd1, 32'd25); chk("pre10", rd2, 32'd20);
`else
        chk("pre9_zero", rd1, 32'd0); chk("pre14_zero", rd2, 32'd0);
`endif
        ra1 = 5'd12;
        @(negedge clk); chk("pre12", rd1, 32'd0);

        // asynchronous reset from RUN with live outputs, then again mid-INIT
        we = 1'b1; wa = 5'd3; wd = 32'h33; mark_en = 1'b1; mark_addr = 5'd3; ra1 = 5'd3;
        @(negedge clk); idle();
        chk("live_rd1", rd1, 32'h33); chk("live_busy", {31'd0, rd1_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rd1", rd1, 32'd0); chk("async_busy", {31'd0, rd1_busy}, 32'd0);
        chk("async_ready", {31'd0, ready}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 10; k++) @(negedge clk);
        chk("mid_init_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        init_window("init_restart");
        @(negedge clk); chk("reg3_after_reset", rd1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
